// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = PC_W'(32'h0000_0000);
  localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = PC_W'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Issuer handshake, instruction-memory port and branch redirect bundle.
interface fetch_if
  import fetch_pkg::*;
;
  logic               triggerIn;
  logic               readyOut;
  logic [INSTR_W-1:0] dataOut;
  logic [PC_W-1:0]    pcOut;
  logic               memReq;
  logic [PC_W-1:0]    memAddr;
  logic               memAck;
  logic [INSTR_W-1:0] memData;
  logic               branchValid;
  logic [PC_W-1:0]    branchTarget;
  logic               protoErr;

  // Fetch unit side.
  modport master (
    input  triggerIn, memAck, memData, branchValid, branchTarget,
    output readyOut, dataOut, pcOut, memReq, memAddr, protoErr
  );

  // Issuer / memory / execute side.
  modport slave (
    output triggerIn, memAck, memData, branchValid, branchTarget,
    input  readyOut, dataOut, pcOut, memReq, memAddr, protoErr
  );

endinterface

// File: rtl/toggle_sync.sv
// Two-flop synchronizer plus phase-change detector for a two-phase input.
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops run through reset so they settle to the input level before release.
  always_ff @(posedge clk) begin
    meta_q <= async_in;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  // Any phase change is one request; edges seen during reset are dropped.
  assign edge_out = (sync_q ^ prev_q) & ~reset;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: toggle-triggered fetch with branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  fetch_state_t       state_q, state_d;
  logic               ready_q, ready_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic               trig_edge;
  logic               mem_done;

  toggle_sync u_trig_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.triggerIn),
    .edge_out (trig_edge)
  );

  assign mem_done = req_q & bus.memAck;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ready_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state, redirect and output-register update logic.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    data_d  = data_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    err_d   = err_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;

    unique case (state_q)
      FETCH: begin
        if (mem_done) begin
          data_d  = bus.memData;
          pc_d    = addr_q;
          ready_d = 1'b1;
          state_d = VALID;
          // The word is still presented; the redirect applies to the next fetch.
          if (bus.branchValid) begin
            pend_d = 1'b1;
            tgt_d  = bus.branchTarget;
          end
        end else if (bus.branchValid) begin
          tgt_d   = bus.branchTarget;
          state_d = DRAIN;
        end
        if (trig_edge) err_d = 1'b1;
      end
      VALID: begin
        if (bus.branchValid) begin
          pend_d = 1'b1;
          tgt_d  = bus.branchTarget;
        end
        if (trig_edge) begin
          ready_d = 1'b0;
          state_d = FETCH;
          pend_d  = 1'b0;
          if (bus.branchValid) addr_d = bus.branchTarget;
          else if (pend_q)     addr_d = tgt_q;
          else                 addr_d = pc_q + PC_STEP;
        end
      end
      DRAIN: begin
        if (mem_done) begin
          state_d = FETCH;
          addr_d  = bus.branchValid ? bus.branchTarget : tgt_q;
        end else if (bus.branchValid) begin
          tgt_d = bus.branchTarget;
        end
        if (trig_edge) err_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // A read is requested in every state except while a word is presented.
    req_d = (state_d != VALID);
  end

  assign bus.readyOut = ready_q;
  assign bus.dataOut  = data_q;
  assign bus.pcOut    = pc_q;
  assign bus.memReq   = req_q;
  assign bus.memAddr  = addr_q;
  assign bus.protoErr = err_q;

endmodule
